tone_generator: RTL
===================

# tone_generator

Audio back end for the piano core. It consumes the registered `note_out` / `octave_out` pair produced by the mode controller and drives the on-board buzzer with a phase-continuous square wave. Pitch changes are applied only at half-period boundaries, so the buzzer sees no glitches. It also reports the currently sounding note for display.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency; all period constants derive from it.
- `CNT_W`, 20: half-period counter width; must hold 2 × the largest middle-octave half-period.
- `clk`  in  1: system clock.
- `reset`  in  1: reset, asynchronous and active-high. It clears all state.
- `enable`  in  1: high plays notes; low forces silence, equivalent to a rest.
- `note_in`  in  4: 0 = rest, 1..7 = do..si (C..B), 8..15 = rest.
- `octave_in`  in  2: 0 = low, 1 = middle, 2 = high, 3 = treated as middle.
- `speaker`  out  1: square-wave drive to the buzzer.
- `playing`  out  1: high while in PLAY.
- `active_note`  out  4: note code currently sounding; 0 when silent.
- `active_octave`  out  2: octave currently sounding, after remapping 3 → 1; 0 when silent.

## Operation
- Input stage: `enable`, `note_in` and `octave_in` are registered every cycle into `en_q`, `note_q` and `oct_q`.
- `valid_q` is true when `en_q` = 1 and `note_q` is in 1..7.
- Middle-octave half-period: `HP[n] = CLK_HZ / (2 × f[n])`, integer division, with f = 262, 294, 330, 349, 392, 440, 494 Hz for n = 1..7.
- Octave scaling:
  - low = `HP << 1`
  - middle = `HP`
  - high = `HP >> 1`
- The result is truncated to `CNT_W` bits. There is no saturation; `CNT_W` is sized to fit.
- `target_hp` is the looked-up half-period for (`note_q`, `oct_q`), evaluated combinationally each cycle.
- FSM states: SILENT, PLAY.
- SILENT:
  - `speaker` = 0, `cnt` = 0, `playing` = 0, active outputs = 0.
  - If `valid_q`: go to PLAY. Load `cur_hp` ← `target_hp`, `active_note`/`active_octave` ← `note_q`/remapped `oct_q`, `cnt` ← 0.
- PLAY, evaluated in this priority order each cycle:
  - If !`valid_q`: go to SILENT. `speaker` ← 0, `cnt` ← 0, active outputs ← 0. This takes effect immediately, without waiting for a boundary.
  - Else if `cnt` == `cur_hp` − 1 (boundary): toggle `speaker`, `cnt` ← 0. Load `cur_hp` ← `target_hp` and refresh `active_note`/`active_octave`. This is the only point at which pitch changes.
  - Else: `cnt` ← `cnt` + 1.
- Changing from one valid note to another never passes through SILENT. The waveform stays phase-continuous and the current half-period completes at the old pitch.

## Timing
- Reset values: SILENT, `speaker` = 0, `playing` = 0, `active_note` = 0, `active_octave` = 0, `cnt` = 0, `cur_hp` = 0, input registers = 0.
- Start latency:
  - `note_in` is valid at edge k and is registered at k.
  - At edge k+1 the block enters PLAY and `playing` goes high.
  - First `speaker` rise occurs at edge k+1+`cur_hp`.
  - After that, `speaker` toggles every `cur_hp` cycles.
- Stop latency: a rest at edge k drives `speaker` = 0 and `playing` = 0 at edge k+1.
- Pitch-change latency: the new pitch applies at the first boundary at or after edge k+1, so the worst case is `cur_hp` cycles.
- Simultaneous events: if the input goes invalid on the same cycle as a boundary, the stop takes priority and there is no toggle.
- `enable` falling is handled exactly like a rest.
- Reset asserted mid-tone forces `speaker` low asynchronously, with no trailing edge.

## Structure
- Package `piano_pkg` holds:
  - note codes (REST, DO..SI)
  - octave codes (LOW, MID, HIGH)
  - frequency constants
  - the FSM state enum
- Sub-module `tone_period_lut`:
  - Combinational. Inputs: `note`, `octave`. Output: `CNT_W`-bit half-period.
  - Parameterized by `CLK_HZ`.
  - Outputs 0 for invalid notes.
- The top level holds the input registers, FSM, counter and output registers.

## Test plan
All scenarios run with `CLK_HZ` = 1_000_000, which gives middle A (note 6, octave 1) HP = 1136, low A = 2272, high A = 568, and middle do (note 1) HP = 1908.

- Reset: hold `reset` with note 6 applied → `speaker` = 0, `playing` = 0, `active_note` = 0. Release → `playing` rises one cycle after the input register.
- Start: note 6, octave 1 applied at edge k → `playing` = 1 at k+1, first `speaker` rise at k+1137, next fall 1136 cycles later.
- Octaves: note 6 at octave 0, then 2, then 3 → measured half-periods 2272, 568, 1136; `active_octave` reads 0, 2, 1.
- Glitch-free change: switch note 6 → note 1 at mid-period → the current half-period completes at 1136 cycles, then half-periods are 1908, and `active_note` changes exactly at the boundary.
- Stop and enable: drive note 0 (or `enable` = 0) during `speaker` = 1 → `speaker` = 0 and `playing` = 0 next cycle. Drive note 9 → stays silent.
- Async reset mid-tone: assert `reset` between edges → `speaker` drops immediately. Release with note 6 held → restart latency is identical to the Start scenario.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared definitions for the piano core: note/octave codes, pitch constants, FSM states.
package piano_pkg;

    // Note codes as produced by the mode controller; 8..15 also mean rest.
    typedef enum logic [3:0] {
        NoteRest = 4'd0,
        NoteDo   = 4'd1,
        NoteRe   = 4'd2,
        NoteMi   = 4'd3,
        NoteFa   = 4'd4,
        NoteSol  = 4'd5,
        NoteLa   = 4'd6,
        NoteSi   = 4'd7
    } note_e;

    // Octave codes; code 3 is treated as middle.
    typedef enum logic [1:0] {
        OctLow  = 2'd0,
        OctMid  = 2'd1,
        OctHigh = 2'd2
    } octave_e;

    // Middle-octave frequencies in Hz.
    localparam int unsigned FreqDo  = 262;
    localparam int unsigned FreqRe  = 294;
    localparam int unsigned FreqMi  = 330;
    localparam int unsigned FreqFa  = 349;
    localparam int unsigned FreqSol = 392;
    localparam int unsigned FreqLa  = 440;
    localparam int unsigned FreqSi  = 494;

    typedef enum logic [0:0] {
        StSilent = 1'b0,
        StPlay   = 1'b1
    } state_e;

    // Half-period in clock cycles for a square wave of the given frequency.
    function automatic int unsigned half_period_cycles(input int unsigned clk_hz,
                                                       input int unsigned freq_hz);
        return clk_hz / (2 * freq_hz);
    endfunction

endpackage

// File: rtl/tone_period_lut.sv
// Combinational half-period lookup for (note, octave); 0 for rests and invalid codes.
module tone_period_lut
    import piano_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned CNT_W  = 20
) (
    input  logic [3:0]       note,
    input  logic [1:0]       octave,
    output logic [CNT_W-1:0] half_period
);

    localparam int unsigned HpDo  = half_period_cycles(CLK_HZ, FreqDo);
    localparam int unsigned HpRe  = half_period_cycles(CLK_HZ, FreqRe);
    localparam int unsigned HpMi  = half_period_cycles(CLK_HZ, FreqMi);
    localparam int unsigned HpFa  = half_period_cycles(CLK_HZ, FreqFa);
    localparam int unsigned HpSol = half_period_cycles(CLK_HZ, FreqSol);
    localparam int unsigned HpLa  = half_period_cycles(CLK_HZ, FreqLa);
    localparam int unsigned HpSi  = half_period_cycles(CLK_HZ, FreqSi);

    int unsigned base_hp;
    int unsigned scaled_hp;

    // Pick the middle-octave period, then shift for the octave; truncation is intentional.
    always_comb begin
        base_hp = 0;
        case (note)
            NoteDo:  base_hp = HpDo;
            NoteRe:  base_hp = HpRe;
            NoteMi:  base_hp = HpMi;
            NoteFa:  base_hp = HpFa;
            NoteSol: base_hp = HpSol;
            NoteLa:  base_hp = HpLa;
            NoteSi:  base_hp = HpSi;
            default: base_hp = 0;
        endcase

        case (octave)
            OctLow:  scaled_hp = base_hp << 1;
            OctHigh: scaled_hp = base_hp >> 1;
            default: scaled_hp = base_hp;
        endcase

        half_period = CNT_W'(scaled_hp);
    end

endmodule

// File: rtl/tone_generator.sv
// Square-wave buzzer driver; pitch changes only land on half-period boundaries.
module tone_generator
    import piano_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned CNT_W  = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] note_in,
    input  logic [1:0] octave_in,
    output logic       speaker,
    output logic       playing,
    output logic [3:0] active_note,
    output logic [1:0] active_octave
);

    logic             en_q;
    logic [3:0]       note_q;
    logic [1:0]       oct_q;
    logic             note_valid;
    logic [1:0]       oct_map;
    logic [CNT_W-1:0] target_hp;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cur_hp_q, cur_hp_d;
    logic             spk_q, spk_d;
    logic [3:0]       act_note_q, act_note_d;
    logic [1:0]       act_oct_q, act_oct_d;

    // Register the controller outputs every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q   <= 1'b0;
            note_q <= 4'd0;
            oct_q  <= 2'd0;
        end else begin
            en_q   <= enable;
            note_q <= note_in;
            oct_q  <= octave_in;
        end
    end

    assign note_valid = en_q && (note_q >= 4'd1) && (note_q <= 4'd7);
    assign oct_map    = (oct_q == 2'd3) ? OctMid : oct_q;

    tone_period_lut #(
        .CLK_HZ (CLK_HZ),
        .CNT_W  (CNT_W)
    ) u_lut (
        .note        (note_q),
        .octave      (oct_q),
        .half_period (target_hp)
    );

    // State, counter and output registers; reset drops the speaker with no trailing edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StSilent;
            cnt_q      <= '0;
            cur_hp_q   <= '0;
            spk_q      <= 1'b0;
            act_note_q <= 4'd0;
            act_oct_q  <= 2'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_hp_q   <= cur_hp_d;
            spk_q      <= spk_d;
            act_note_q <= act_note_d;
            act_oct_q  <= act_oct_d;
        end
    end

    // Next-state logic: stop beats boundary, boundary is the only place pitch is reloaded.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_hp_d   = cur_hp_q;
        spk_d      = spk_q;
        act_note_d = act_note_q;
        act_oct_d  = act_oct_q;

        unique case (state_q)
            StSilent: begin
                spk_d      = 1'b0;
                cnt_d      = '0;
                act_note_d = 4'd0;
                act_oct_d  = 2'd0;
                if (note_valid) begin
                    state_d    = StPlay;
                    cur_hp_d   = target_hp;
                    act_note_d = note_q;
                    act_oct_d  = oct_map;
                end
            end
            StPlay: begin
                if (!note_valid) begin
                    state_d    = StSilent;
                    spk_d      = 1'b0;
                    cnt_d      = '0;
                    act_note_d = 4'd0;
                    act_oct_d  = 2'd0;
                end else if (cnt_q == cur_hp_q - CNT_W'(1)) begin
                    spk_d      = ~spk_q;
                    cnt_d      = '0;
                    cur_hp_d   = target_hp;
                    act_note_d = note_q;
                    act_oct_d  = oct_map;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StSilent;
        endcase
    end

    assign speaker       = spk_q;
    assign playing       = (state_q == StPlay);
    assign active_note   = act_note_q;
    assign active_octave = act_oct_q;

endmodule
